// File: rtl/zeta_sched.sv
// NTT butterfly scheduler: walks the forward or inverse Cooley-Tukey/Gentleman-Sande
// layer order and streams (idx_a, idx_b, zeta, layer, last) per butterfly.
module zeta_sched #(
  parameter int N       = 256,
  parameter int WIDTH   = 16,
  parameter int MIN_LEN = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            mode,
  input  logic                            abort,
  output logic                            busy,
  output logic                            done,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(N)-1:0]            idx_a,
  output logic [$clog2(N)-1:0]            idx_b,
  output logic signed [WIDTH-1:0]         zeta,
  output logic [$clog2($clog2(N)):0]      layer,
  output logic                            last,
  output logic [1:0]                      dbg_state
);

  localparam int AW = $clog2(N);
  localparam int LW = $clog2(AW) + 1;

  // Kyber zeta table in centred Montgomery form, indexed by bit-reversed k.
  localparam logic signed [15:0] KYBER_ZETAS [0:127] = '{
    -16'sd1044,  -16'sd758,  -16'sd359, -16'sd1517,  16'sd1493,  16'sd1422,   16'sd287,   16'sd202,
     -16'sd171,   16'sd622,  16'sd1577,   16'sd182,   16'sd962, -16'sd1202, -16'sd1474,  16'sd1468,
      16'sd573, -16'sd1325,   16'sd264,   16'sd383,  -16'sd829,  16'sd1458, -16'sd1602,  -16'sd130,
     -16'sd681,  16'sd1017,   16'sd732,   16'sd608, -16'sd1542,   16'sd411,  -16'sd205, -16'sd1571,
     16'sd1223,   16'sd652,  -16'sd552,  16'sd1015, -16'sd1293,  16'sd1491,  -16'sd282, -16'sd1544,
      16'sd516,    -16'sd8,  -16'sd320,  -16'sd666, -16'sd1618, -16'sd1162,   16'sd126,  16'sd1469,
     -16'sd853,   -16'sd90,  -16'sd271,   16'sd830,   16'sd107, -16'sd1421,  -16'sd247,  -16'sd951,
     -16'sd398,   16'sd961, -16'sd1508,  -16'sd725,   16'sd448, -16'sd1065,   16'sd677, -16'sd1275,
    -16'sd1103,   16'sd430,   16'sd555,   16'sd843, -16'sd1251,   16'sd871,  16'sd1550,   16'sd105,
      16'sd422,   16'sd587,   16'sd177,  -16'sd235,  -16'sd291,  -16'sd460,  16'sd1574,  16'sd1653,
     -16'sd246,   16'sd778,  16'sd1159,  -16'sd147,  -16'sd777,  16'sd1483,  -16'sd602,  16'sd1119,
    -16'sd1590,   16'sd644,  -16'sd872,   16'sd349,   16'sd418,   16'sd329,  -16'sd156,   -16'sd75,
      16'sd817,  16'sd1097,   16'sd603,   16'sd610,  16'sd1322, -16'sd1285, -16'sd1465,   16'sd384,
    -16'sd1215,  -16'sd136,  16'sd1218, -16'sd1335,  -16'sd874,   16'sd220, -16'sd1187, -16'sd1659,
    -16'sd1185, -16'sd1530, -16'sd1278,   16'sd794, -16'sd1510,  -16'sd854,  -16'sd870,   16'sd478,
     -16'sd108,  -16'sd308,   16'sd996,   16'sd991,   16'sd958, -16'sd1460,  16'sd1522,  16'sd1628
  };

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

  state_t                  state_q, state_d;
  logic                    mode_q;
  logic [AW-1:0]           len_q, base_q, j_q, k_q;
  logic [LW-1:0]           layer_q;
  logic signed [WIDTH-1:0] zeta_q;

  logic [AW:0]             base_next;
  logic [6:0]              rom_addr;
  logic                    xfer, grp_end, layer_end, fin;

  // Handshake: a butterfly transfers on a rising edge where out_valid & out_ready;
  // while out_valid & !out_ready every output holds. abort withdraws out_valid
  // in the same cycle, so it always wins over a pending transfer.
  assign xfer      = out_valid & out_ready;
  assign base_next = {1'b0, base_q} + ({1'b0, len_q} << 1);
  assign grp_end   = (j_q == len_q - AW'(1));
  assign layer_end = grp_end & (base_next == (AW+1)'(N));
  assign fin       = layer_end & (mode_q ? (len_q == AW'(N/2)) : (len_q == AW'(MIN_LEN)));
  assign rom_addr  = 7'(k_q);

  assign idx_a     = base_q + j_q;
  assign idx_b     = base_q + j_q + len_q;
  assign zeta      = zeta_q;
  assign layer     = layer_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    busy      = (state_q != IDLE);
    done      = (state_q == DONE) & ~abort;
    out_valid = (state_q == EMIT) & ~abort;
    last      = (state_q == EMIT) & ~abort & fin;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = EMIT;
      EMIT: begin
        if (xfer && fin)          state_d = DONE;
        else if (xfer && grp_end) state_d = FETCH;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
      j_q     <= '0;
      k_q     <= '0;
      layer_q <= '0;
      zeta_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start && !abort) begin
          mode_q  <= mode;
          len_q   <= mode ? AW'(MIN_LEN) : AW'(N/2);
          base_q  <= '0;
          j_q     <= '0;
          k_q     <= mode ? AW'(N/2 - 1) : AW'(1);
          layer_q <= '0;
        end
        FETCH: if (!abort) zeta_q <= WIDTH'(KYBER_ZETAS[rom_addr]);
        EMIT: if (xfer) begin
          if (!grp_end) begin
            j_q <= j_q + AW'(1);
          end else if (!fin) begin
            // Final butterfly leaves k/len/layer untouched so k never leaves [1, N/2-1].
            j_q <= '0;
            k_q <= mode_q ? k_q - AW'(1) : k_q + AW'(1);
            if (layer_end) begin
              base_q  <= '0;
              layer_q <= layer_q + LW'(1);
              len_q   <= mode_q ? (len_q << 1) : (len_q >> 1);
            end else begin
              base_q  <= base_next[AW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_zeta_sched.sv
// Scoreboard bench for zeta_sched: a loop-based schedule model fills exp_q, the
// monitor pops on every transfer; a second N=16 instance covers the small case.
module tb_zeta_sched;

  logic clk = 1'b0;
  logic rst, start, mode, abort, out_ready;
  logic busy, done, out_valid, last;
  logic [7:0] idx_a, idx_b;
  logic signed [15:0] zeta;
  logic [3:0] layer;
  logic [1:0] dbg_state;

  logic s_start, s_mode, s_abort, s_ready;
  logic s_busy, s_done, s_valid, s_last;
  logic [3:0] s_idx_a, s_idx_b;
  logic signed [15:0] s_zeta;
  logic [2:0] s_layer;
  logic [1:0] s_dbg_state;

  zeta_sched #(.N(256), .WIDTH(16), .MIN_LEN(2)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .abort(abort),
    .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .idx_a(idx_a), .idx_b(idx_b), .zeta(zeta), .layer(layer), .last(last),
    .dbg_state(dbg_state)
  );

  zeta_sched #(.N(16), .WIDTH(16), .MIN_LEN(4)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .abort(s_abort),
    .busy(s_busy), .done(s_done), .out_valid(s_valid), .out_ready(s_ready),
    .idx_a(s_idx_a), .idx_b(s_idx_b), .zeta(s_zeta), .layer(s_layer), .last(s_last),
    .dbg_state(s_dbg_state)
  );

  always #5 clk = ~clk;

  int ZT [128] = '{
    -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,  -171,   622,  1577,   182,   962, -1202, -1474,  1468,
      573, -1325,   264,   383,  -829,  1458, -1602,  -130,  -681,  1017,   732,   608, -1542,   411,  -205, -1571,
     1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,   516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
     -853,   -90,  -271,   830,   107, -1421,  -247,  -951,  -398,   961, -1508,  -725,   448, -1065,   677, -1275,
    -1103,   430,   555,   843, -1251,   871,  1550,   105,   422,   587,   177,  -235,  -291,  -460,  1574,  1653,
     -246,   778,  1159,  -147,  -777,  1483,  -602,  1119, -1590,   644,  -872,   349,   418,   329,  -156,   -75,
      817,  1097,   603,   610,  1322, -1285, -1465,   384, -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
    -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,  -108,  -308,   996,   991,   958, -1460,  1522,  1628
  };

  logic [36:0] exp_q [$];
  int n_chk = 0, n_fail = 0;
  int n_xfer, busy_cnt, done_cnt, s_xfer, s_busy_cnt, s_done_cnt;
  logic [36:0] cur, held, first_pk, last_pk;
  bit hold_pend = 0, got_first;
  int rdy_mode = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [36:0] pk(input int a, input int b, input int z, input int l, input int lst);
    return {a[7:0], b[7:0], z[15:0], l[3:0], lst[0]};
  endfunction

  // Reference schedule written as the textbook nested loops.
  task automatic build_exp(input int n, input int min_len, input bit inv);
    int k, lay;
    lay = 0;
    if (!inv) begin
      k = 1;
      for (int len = n / 2; len >= min_len; len = len / 2) begin
        for (int st = 0; st < n; st += 2 * len) begin
          for (int j = 0; j < len; j++)
            exp_q.push_back(pk(st + j, st + j + len, ZT[k], lay,
                               int'(len == min_len && st + 2 * len == n && j == len - 1)));
          k++;
        end
        lay++;
      end
    end else begin
      k = n / 2 - 1;
      for (int len = min_len; len <= n / 2; len = len * 2) begin
        for (int st = 0; st < n; st += 2 * len) begin
          for (int j = 0; j < len; j++)
            exp_q.push_back(pk(st + j, st + j + len, ZT[k], lay,
                               int'(len == n / 2 && st + 2 * len == n && j == len - 1)));
          k--;
        end
        lay++;
      end
    end
  endtask

  always @(posedge rst) hold_pend = 0;

  always @(negedge clk) begin
    logic [36:0] e;
    if (rdy_mode == 0)      out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else                    out_ready = 1'b0;
    cur = pk(int'(idx_a), int'(idx_b), int'(zeta), int'(layer), int'(last));
    if (hold_pend && !abort && !rst) chk("hold_stable", 64'(cur), 64'(held));
    hold_pend = out_valid && !out_ready && !abort && !rst;
    held = cur;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (out_valid && out_ready) begin
      if (!got_first) begin first_pk = cur; got_first = 1; end
      last_pk = cur;
      n_xfer++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("xfer", 64'(cur), 64'(e));
    end
  end

  always @(negedge clk) begin
    logic [36:0] e;
    if (s_busy) s_busy_cnt++;
    if (s_done) s_done_cnt++;
    if (s_valid && s_ready) begin
      s_xfer++;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : '1;
      chk("s_xfer", 64'(pk(int'(s_idx_a), int'(s_idx_b), int'(s_zeta), int'(s_layer), int'(s_last))), 64'(e));
    end
  end

  task automatic clear_counts();
    n_xfer = 0; busy_cnt = 0; done_cnt = 0; got_first = 0;
    s_xfer = 0; s_busy_cnt = 0; s_done_cnt = 0;
  endtask

  task automatic kick(input bit m);
    @(posedge clk); #1;
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int max_cyc);
    int c = 0;
    while (done_cnt == 0 && s_done_cnt == 0 && c < max_cyc) begin
      @(posedge clk); c++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic full_run(input string tag, input bit inv, input int max_cyc, input bit timed);
    clear_counts();
    build_exp(256, 2, inv);
    kick(inv);
    wait_done(max_cyc);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    chk({tag, "_xfers"}, 64'(n_xfer), 64'(896));
    chk({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    if (timed) chk({tag, "_cycles"}, 64'(busy_cnt), 64'(1024));
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, lay_at;
    rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
    s_start = 1'b0; s_mode = 1'b0; s_abort = 1'b0; s_ready = 1'b1;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_last", 64'(last), 64'(0));
    chk("rst_outs", 64'(pk(int'(idx_a), int'(idx_b), int'(zeta), int'(layer), 0)), 64'(0));
    rst = 1'b0;

    rdy_mode = 0;
    full_run("fwd", 1'b0, 1100, 1'b1);
    chk("fwd_first", 64'(first_pk), 64'(pk(0, 128, -758, 0, 0)));
    chk("fwd_final", 64'(last_pk), 64'(pk(253, 255, 1628, 6, 1)));

    full_run("inv", 1'b1, 1100, 1'b1);
    chk("inv_first", 64'(first_pk), 64'(pk(0, 2, 1628, 0, 0)));
    chk("inv_final", 64'(last_pk), 64'(pk(127, 255, -758, 6, 1)));

    rdy_mode = 1;
    full_run("bp", 1'b0, 5000, 1'b0);
    chk("bp_final", 64'(last_pk), 64'(pk(253, 255, 1628, 6, 1)));

    // Abort in layer 3 while the consumer stalls.
    clear_counts();
    build_exp(256, 2, 1'b0);
    kick(1'b0);
    c = 0;
    while (!(layer == 4'd3 && out_valid) && c < 3000) begin
      @(posedge clk); #1; c++;
    end
    lay_at = int'(layer);
    rdy_mode = 2;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_layer", 64'(lay_at), 64'(3));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_valid", 64'(out_valid), 64'(0));
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt), 64'(0));
    exp_q.delete();
    rdy_mode = 0;
    full_run("replay", 1'b0, 1100, 1'b1);
    chk("replay_first", 64'(first_pk), 64'(pk(0, 128, -758, 0, 0)));

    // Asynchronous reset between edges, then a start issued while busy.
    clear_counts();
    build_exp(256, 2, 1'b0);
    kick(1'b0);
    repeat (200) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_outs", 64'(pk(int'(idx_a), int'(idx_b), int'(zeta), int'(layer), int'(last))), 64'(0));
    #1 rst = 1'b0;
    exp_q.delete();
    clear_counts();
    build_exp(256, 2, 1'b0);
    kick(1'b0);
    repeat (300) @(posedge clk);
    #1;
    start = 1'b1; mode = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(1100);
    chk("busy_start_done", 64'(done_cnt), 64'(1));
    chk("busy_start_xfers", 64'(n_xfer), 64'(896));
    chk("busy_start_queue", 64'(exp_q.size()), 64'(0));
    chk("busy_start_cycles", 64'(busy_cnt), 64'(1024));
    exp_q.delete();

    // Small instance: N=16, MIN_LEN=4 gives layers len 8 and 4 with k = 1..3.
    clear_counts();
    build_exp(16, 4, 1'b0);
    @(posedge clk); #1;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    wait_done(100);
    chk("small_done", 64'(s_done_cnt), 64'(1));
    chk("small_xfers", 64'(s_xfer), 64'(16));
    chk("small_queue", 64'(exp_q.size()), 64'(0));
    chk("small_cycles", 64'(s_busy_cnt), 64'(20));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
